// File: rtl/pixel_sampler.sv
// Decimates an aligned RGB stream to the LED matrix size by nearest-neighbour sampling with error accumulators.
// Latency: one write registered 1 cycle after the sampled DE cycle; frame_done/size_error 1 cycle after the frame strobe.
// Backpressure: none; at most one write per clock, and the consumer must accept every write.
module pixel_sampler #(
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080,
  parameter int OUT_WIDTH  = 128,
  parameter int OUT_HEIGHT = 64,
  parameter int DATA_WIDTH = 24
) (
  input  logic                          I_rgb_clk,
  input  logic                          I_rst_n,
  input  logic                          I_rgb_de,
  input  logic [DATA_WIDTH-1:0]         I_rgb_data,
  input  logic                          I_new_row,
  input  logic                          I_new_frame,
  input  logic [$clog2(MAX_WIDTH)-1:0]  I_image_width,
  input  logic [$clog2(MAX_HEIGHT)-1:0] I_image_height,
  input  logic                          I_image_valid,
  output logic                          O_wr_en,
  output logic [$clog2(OUT_WIDTH)-1:0]  O_wr_x,
  output logic [$clog2(OUT_HEIGHT)-1:0] O_wr_y,
  output logic [DATA_WIDTH-1:0]         O_wr_data,
  output logic                          O_frame_done,
  output logic                          O_size_error
);

  localparam int WW = $clog2(MAX_WIDTH);
  localparam int HW = $clog2(MAX_HEIGHT);
  localparam int XW = $clog2(OUT_WIDTH);
  localparam int YW = $clog2(OUT_HEIGHT);

  // Matrix sizes at accumulator width and at counter width (counters need one
  // extra bit so they can sit at the saturated value OUT_WIDTH / OUT_HEIGHT).
  localparam logic [WW:0] OUT_W_ACC = (WW+1)'(OUT_WIDTH);
  localparam logic [HW:0] OUT_H_ACC = (HW+1)'(OUT_HEIGHT);
  localparam logic [XW:0] OUT_W_CNT = (XW+1)'(OUT_WIDTH);
  localparam logic [YW:0] OUT_H_CNT = (YW+1)'(OUT_HEIGHT);

  logic [WW:0] geo_w;
  logic [HW:0] geo_h;
  logic        frame_active;
  logic [WW:0] acc_x;
  logic [WW:0] nx;
  logic [HW:0] acc_y;
  logic [HW:0] acc_y_plus;
  logic [XW:0] out_x;
  logic [YW:0] out_y;
  logic        row_seen;
  logic        size_ok;
  logic        row_sel;
  logic        pix_ok;
  logic        col_hit;
  logic        emit;

  // Sampling decisions: geometry check, row/column selection and write strobe.
  always_comb begin
    size_ok    = ({1'b0, I_image_width} >= OUT_W_ACC) && ({1'b0, I_image_height} >= OUT_H_ACC);
    acc_y_plus = acc_y + OUT_H_ACC;
    row_sel    = (acc_y_plus >= geo_h) && (out_y < OUT_H_CNT);
    nx         = acc_x + OUT_W_ACC;
    // Strobes take priority, so a DE pixel that coincides with one is dropped.
    pix_ok     = frame_active & I_rgb_de & ~I_new_row & ~I_new_frame;
    col_hit    = pix_ok && (nx >= geo_w);
    emit       = col_hit && row_sel && (out_x < OUT_W_CNT);
  end

  // Geometry latch plus horizontal/vertical error accumulators and output counters.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      geo_w        <= '0;
      geo_h        <= '0;
      frame_active <= 1'b0;
      acc_x        <= '0;
      acc_y        <= '0;
      out_x        <= '0;
      out_y        <= '0;
      row_seen     <= 1'b0;
    end else if (I_new_frame) begin
      // Resetting everything also stands in for the last row's end update.
      geo_w        <= {1'b0, I_image_width};
      geo_h        <= {1'b0, I_image_height};
      frame_active <= I_image_valid & size_ok;
      acc_x        <= '0;
      acc_y        <= '0;
      out_x        <= '0;
      out_y        <= '0;
      row_seen     <= 1'b0;
    end else if (frame_active) begin
      if (I_new_row) begin
        acc_x    <= '0;
        out_x    <= '0;
        row_seen <= 1'b0;
        // Blank rows (no DE) leave the vertical state untouched.
        if (row_seen) begin
          if (row_sel) begin
            acc_y <= acc_y_plus - geo_h;
            out_y <= out_y + 1'b1;
          end else begin
            acc_y <= acc_y_plus;
          end
        end
      end else if (pix_ok) begin
        row_seen <= 1'b1;
        if (col_hit) begin
          acc_x <= nx - geo_w;
          if (out_x != OUT_W_CNT) begin
            out_x <= out_x + 1'b1;
          end
        end else begin
          acc_x <= nx;
        end
      end
    end
  end

  // Registered write port and frame status; write fields hold while idle.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_wr_en      <= 1'b0;
      O_wr_x       <= '0;
      O_wr_y       <= '0;
      O_wr_data    <= '0;
      O_frame_done <= 1'b0;
      O_size_error <= 1'b0;
    end else begin
      O_wr_en      <= emit;
      O_frame_done <= I_new_frame & frame_active;
      if (emit) begin
        O_wr_x    <= out_x[XW-1:0];
        O_wr_y    <= out_y[YW-1:0];
        O_wr_data <= I_rgb_data;
      end
      if (I_new_frame) begin
        O_size_error <= I_image_valid & ~size_ok;
      end
    end
  end

endmodule

// File: tb/tb_pixel_sampler.sv
// Directed bench for pixel_sampler with a write scoreboard.
// Expected writes are derived from closed-form source/matrix coordinate mappings.
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_pixel_sampler;

  typedef struct packed {
    logic [6:0]  x;
    logic [5:0]  y;
    logic [23:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        de = 1'b0;
  logic [23:0] data = '0;
  logic        new_row = 1'b0;
  logic        new_frame = 1'b0;
  logic [10:0] img_w = '0;
  logic [10:0] img_h = '0;
  logic        img_valid = 1'b0;
  logic        wr_en;
  logic [6:0]  wr_x;
  logic [5:0]  wr_y;
  logic [23:0] wr_data;
  logic        frame_done;
  logic        size_error;

  int   checks = 0;
  int   failures = 0;
  int   mode = 0;        // 0: no writes, 1: 256x128, 2: identity, 3: 1920x1080
  int   wr_count = 0;
  logic prev_en = 1'b0;
  wr_t  q[$];
  wr_t  got;
  wr_t  want;

  always #5 clk = ~clk;

  pixel_sampler dut (
    .I_rgb_clk     (clk),
    .I_rst_n       (rst_n),
    .I_rgb_de      (de),
    .I_rgb_data    (data),
    .I_new_row     (new_row),
    .I_new_frame   (new_frame),
    .I_image_width (img_w),
    .I_image_height(img_h),
    .I_image_valid (img_valid),
    .O_wr_en       (wr_en),
    .O_wr_x        (wr_x),
    .O_wr_y        (wr_y),
    .O_wr_data     (wr_data),
    .O_frame_done  (frame_done),
    .O_size_error  (size_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix(input int c, input int r);
    return {r[11:0], c[11:0]};
  endfunction

  // Selected source rows for H=1080 -> 64: row j is the smallest r with (r+1)*64 >= (j+1)*1080.
  function automatic int sel_idx(input int r);
    for (int j = 0; j < 64; j++) begin
      if (r == ((j + 1) * 1080 + 63) / 64 - 1) return j;
    end
    return -1;
  endfunction

  function automatic bit exp_wr(input int c, input int r, output wr_t e);
    int j;
    e = '0;
    e.d = pix(c, r);
    case (mode)
      1: if ((c % 2 == 1) && (r % 2 == 1)) begin
        e.x = 7'(c / 2);
        e.y = 6'(r / 2);
        return 1'b1;
      end
      2: begin
        e.x = 7'(c);
        e.y = 6'(r);
        return 1'b1;
      end
      3: begin
        j = sel_idx(r);
        if ((j >= 0) && (c % 15 == 14)) begin
          e.x = 7'(c / 15);
          e.y = 6'(j);
          return 1'b1;
        end
      end
      default: ;
    endcase
    return 1'b0;
  endfunction

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_count++;
      got = '{x: wr_x, y: wr_y, d: wr_data};
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write: observed %0h expected none", got);
      end
      if (q.size() != 0) begin
        want = q.pop_front();
        checks++;
        assert (got === want) else begin
          failures++;
          $error("FAIL write_content: observed %0h expected %0h", got, want);
        end
      end
      if (mode == 3) begin
        checks++;
        assert (prev_en === 1'b0) else begin
          failures++;
          $error("FAIL back_to_back: observed %0b expected 0", prev_en);
        end
      end
    end
    prev_en = wr_en;
  end

  task automatic start_frame(input int w, input int h, input logic v, input int m,
                             input logic exp_done, input logic exp_err);
    new_frame = 1'b1;
    de        = 1'b0;
    img_w     = 11'(w);
    img_h     = 11'(h);
    img_valid = v;
    cyc();
    new_frame = 1'b0;
    chk("frame_done", 64'(frame_done), 64'(exp_done));
    chk("size_error", 64'(size_error), 64'(exp_err));
    mode     = m;
    wr_count = 0;
  endtask

  task automatic drive_row(input int r, input int ncols, input logic de_on_strobe);
    wr_t e;
    new_row = 1'b1;
    de      = de_on_strobe;
    data    = 24'hABCDEF;
    cyc();
    new_row = 1'b0;
    for (int c = 0; c < ncols; c++) begin
      de   = 1'b1;
      data = pix(c, r);
      if (exp_wr(c, r, e)) q.push_back(e);
      cyc();
    end
    de = 1'b0;
    cyc();
  endtask

  task automatic drain(input string tag);
    cyc();
    cyc();
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_x", 64'(wr_x), 64'd0);
    chk("rst_wr_y", 64'(wr_y), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_size_error", 64'(size_error), 64'd0);
    rst_n = 1'b1;
    cyc();

    // 256x128 -> odd columns of odd rows; DE on every row strobe must be dropped
    start_frame(256, 128, 1'b1, 1, 1'b0, 1'b0);
    for (int r = 0; r < 128; r++) drive_row(r, 256, 1'b1);
    drain("drain_256");
    chk("count_256", 64'(wr_count), 64'd8192);

    // 128x64 identity
    start_frame(128, 64, 1'b1, 2, 1'b1, 1'b0);
    for (int r = 0; r < 64; r++) drive_row(r, 128, 1'b0);
    drain("drain_identity");
    chk("count_identity", 64'(wr_count), 64'd8192);

    // 1920x1080: full rows only where writes land (16, 33); other rows carry one pixel
    start_frame(1920, 1080, 1'b1, 3, 1'b1, 1'b0);
    for (int r = 0; r < 34; r++) drive_row(r, (r == 16 || r == 33) ? 1920 : 1, 1'b0);
    drain("drain_1920");
    chk("count_1920", 64'(wr_count), 64'd256);

    // Too narrow: size error, no writes
    start_frame(100, 64, 1'b1, 0, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) drive_row(r, 100, 1'b0);
    drain("drain_narrow");
    chk("count_narrow", 64'(wr_count), 64'd0);

    // Geometry not valid: no error, no writes, no done for the narrow frame
    start_frame(128, 64, 1'b0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) drive_row(r, 128, 1'b0);
    drain("drain_invalid");
    chk("count_invalid", 64'(wr_count), 64'd0);

    // Valid again, then reset mid-row
    start_frame(128, 64, 1'b1, 2, 1'b0, 1'b0);
    drive_row(0, 128, 1'b0);
    drive_row(1, 128, 1'b0);
    drive_row(2, 10, 1'b0);
    cyc();
    chk("hold_en", 64'(wr_en), 64'd0);
    chk("hold_x", 64'(wr_x), 64'd9);
    chk("hold_y", 64'(wr_y), 64'd2);
    chk("hold_data", 64'(wr_data), 64'(pix(9, 2)));
    chk("q_before_reset", 64'(q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_x", 64'(wr_x), 64'd0);
    chk("mid_rst_wr_y", 64'(wr_y), 64'd0);
    chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
    #2 rst_n = 1'b1;
    mode = 0;
    wr_count = 0;
    for (int c = 10; c < 128; c++) begin
      de   = 1'b1;
      data = pix(c, 2);
      cyc();
    end
    de = 1'b0;
    cyc();
    for (int r = 3; r < 6; r++) drive_row(r, 128, 1'b0);
    drain("drain_after_reset");
    chk("count_after_reset", 64'(wr_count), 64'd0);

    // Writes resume at the next valid frame; reset cleared the old frame's activity
    start_frame(128, 64, 1'b1, 2, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) drive_row(r, 128, 1'b0);
    drain("drain_resume");
    chk("count_resume", 64'(wr_count), 64'd256);
    start_frame(128, 64, 1'b0, 0, 1'b1, 1'b0);
    cyc();
    chk("frame_done_pulse", 64'(frame_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
